// File: rtl/vcfg_issue.sv
// Vector-config issue stage: decodes vsetvli/vsetivli/vsetvl, computes VLMAX/vl/vill
// and drives a one-cycle CSR write. Optional macro VCFG_AVL_SPLIT_EN balances vl when VLMAX < AVL < 2*VLMAX.
module vcfg_issue #(
    parameter int VLEN = 256,
    parameter int ELEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] vl_cur,
    output logic        vconfig_wr_en,
    output logic [31:0] vl_in,
    output logic [31:0] vtype_in,
    output logic        vill,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        illegal
);
    localparam int LOG2_VLEN = $clog2(VLEN);
    localparam int LOG2_ELEN = $clog2(ELEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:15] hi_q;
    logic [4:0]  rd_q, rd_addr_q;
    logic [31:0] rs1_q, rs2_q;
    logic        illegal_q;
    logic [31:0] vl_q, vl_d, vtype_q, vtype_d;
    logic        vill_q, vill_d;

    logic        in_cfg, is_ivli, is_vl, keep_vl;
    logic [10:0] zimm;
    logic [2:0]  vsew, vlmul;
    logic [7:0]  exp_s;
    logic [31:0] vlmax, avl;

    assign in_cfg = (instr[6:0] == 7'b1010111) && (instr[14:12] == 3'b111) &&
                    (!instr[31] || (instr[31:30] == 2'b11) || (instr[31:25] == 7'b1000000));

    always_comb begin
        is_ivli = (hi_q[31:30] == 2'b11);
        is_vl   = (hi_q[31:25] == 7'b1000000);
        if (is_vl)        zimm = rs2_q[10:0];
        else if (is_ivli) zimm = {1'b0, hi_q[29:20]};
        else              zimm = hi_q[30:20];
        vsew  = zimm[5:3];
        vlmul = zimm[2:0];
        // Exponent is small and signed; bit 7 flags a fractional VLMAX.
        exp_s = 8'(LOG2_VLEN - 3) - 8'(vsew) + {{5{vlmul[2]}}, vlmul};
        vlmax = exp_s[7] ? 32'd0 : (32'd1 << exp_s[4:0]);

        keep_vl = !is_ivli && (hi_q[19:15] == 5'd0) && (rd_q == 5'd0);
        if (is_ivli)                  avl = {27'd0, hi_q[19:15]};
        else if (hi_q[19:15] != 5'd0) avl = rs1_q;
        else                          avl = 32'hFFFF_FFFF;

        vill_d = (vlmul == 3'b100) || (vsew > 3'(LOG2_ELEN - 3)) || exp_s[7] ||
                 (zimm[10:8] != 3'd0) || (is_vl && (rs2_q[31:11] != 21'd0));

        if (keep_vl)          vl_d = (vl_cur < vlmax) ? vl_cur : vlmax;
        else if (avl < vlmax) vl_d = avl;
        else                  vl_d = vlmax;
`ifdef VCFG_AVL_SPLIT_EN
        if (!keep_vl && (avl > vlmax) && ({1'b0, avl} < {vlmax, 1'b0}))
            vl_d = (avl >> 1) + {31'd0, avl[0]};
`endif
        vtype_d = {1'b0, zimm, 20'd0};
        if (vill_d) begin
            vl_d    = 32'd0;
            vtype_d = 32'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = in_cfg ? CALC : DONE;
            CALC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            illegal_q <= 1'b0;
            vl_q      <= '0;
            vtype_q   <= '0;
            vill_q    <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                hi_q      <= instr[31:15];
                rd_q      <= instr[11:7];
                rs1_q     <= rs1_data;
                rs2_q     <= rs2_data;
                illegal_q <= !in_cfg;
            end
            // Results only move in CALC so the CSR-facing data holds between writes.
            if (state_q == CALC) begin
                vl_q      <= vl_d;
                vtype_q   <= vtype_d;
                vill_q    <= vill_d;
                rd_addr_q <= rd_q;
            end
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign vconfig_wr_en = (state_q == DONE) && !illegal_q;
    assign illegal       = (state_q == DONE) && illegal_q;
    assign rd_we         = (state_q == DONE) && !illegal_q && (rd_addr_q != 5'd0);
    assign vl_in         = vl_q;
    assign rd_data       = vl_q;
    assign vtype_in      = vtype_q;
    assign vill          = vill_q;
    assign rd_addr       = rd_addr_q;
endmodule

// File: tb/tb_vcfg_issue.sv
// Directed bench for vcfg_issue: hand-computed vectors checked with immediate assertions.
module tb_vcfg_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0, rs1_data = '0, rs2_data = '0, vl_cur = '0;
    logic        vconfig_wr_en, vill, rd_we, illegal;
    logic [31:0] vl_in, vtype_in, rd_data;
    logic [4:0]  rd_addr;

    int n_cmp = 0;
    int n_err = 0;

    vcfg_issue #(.VLEN(256), .ELEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .vl_cur(vl_cur),
        .vconfig_wr_en(vconfig_wr_en), .vl_in(vl_in), .vtype_in(vtype_in), .vill(vill),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_vli(input logic [10:0] z, input logic [4:0] rs1, input logic [4:0] rd);
        return {1'b0, z, rs1, 3'b111, rd, 7'b1010111};
    endfunction
    function automatic logic [31:0] enc_ivli(input logic [9:0] z, input logic [4:0] u, input logic [4:0] rd);
        return {2'b11, z, u, 3'b111, rd, 7'b1010111};
    endfunction
    function automatic logic [31:0] enc_vl(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    // Handshake, check the CALC cycle (optionally changing vl_cur there), stop in DONE.
    task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] vc0, input logic [31:0] vc1);
        instr = ins; rs1_data = r1; rs2_data = r2; vl_cur = vc0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; vl_cur = vc1; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'hDEAD_BEEF;
        chk({tag, ".calc_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, ".calc_wr"}, {31'd0, vconfig_wr_en}, 32'd0);
        @(negedge clk);
    endtask

    task automatic done_chk(input string tag, input logic [31:0] evl, input logic [31:0] evt,
                            input logic evill, input logic ewe, input logic [4:0] erd);
        chk({tag, ".wr_en"}, {31'd0, vconfig_wr_en}, 32'd1);
        chk({tag, ".vl"}, vl_in, evl);
        chk({tag, ".vtype"}, vtype_in, evt);
        chk({tag, ".vill"}, {31'd0, vill}, {31'd0, evill});
        chk({tag, ".rd_we"}, {31'd0, rd_we}, {31'd0, ewe});
        if (ewe) chk({tag, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, erd});
        chk({tag, ".rd_data"}, rd_data, evl);
        chk({tag, ".illegal"}, {31'd0, illegal}, 32'd0);
        @(negedge clk);
        chk({tag, ".post_wr"}, {31'd0, vconfig_wr_en}, 32'd0);
        chk({tag, ".post_we"}, {31'd0, rd_we}, 32'd0);
        chk({tag, ".post_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".hold_vl"}, vl_in, evl);
    endtask

    initial begin
        #1;
        chk("rst.ready", {31'd0, in_ready}, 32'd1);
        chk("rst.wr", {31'd0, vconfig_wr_en}, 32'd0);
        chk("rst.vl", vl_in, 32'd0);
        chk("rst.vtype", vtype_in, 32'd0);
        chk("rst.vill", {31'd0, vill}, 32'd0);
        chk("rst.rd_we", {31'd0, rd_we}, 32'd0);
        chk("rst.rd_addr", {27'd0, rd_addr}, 32'd0);
        chk("rst.rd_data", rd_data, 32'd0);
        chk("rst.illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        issue("e32m1", enc_vli(11'h010, 5'd1, 5'd5), 32'd20, 32'd0, 32'd0, 32'd0);
        done_chk("e32m1", 32'd8, 32'h0100_0000, 1'b0, 1'b1, 5'd5);

        issue("e8m2", enc_vli(11'h001, 5'd2, 5'd6), 32'd40, 32'd0, 32'd0, 32'd0);
        done_chk("e8m2", 32'd40, 32'h0010_0000, 1'b0, 1'b1, 5'd6);

        issue("ivli", enc_ivli(10'h00F, 5'd5, 5'd7), 32'd0, 32'd0, 32'd0, 32'd0);
        done_chk("ivli", 32'd5, 32'h00F0_0000, 1'b0, 1'b1, 5'd7);

        issue("vlmax", enc_vli(11'h001, 5'd0, 5'd9), 32'd0, 32'd0, 32'd0, 32'd0);
        done_chk("vlmax", 32'd64, 32'h0010_0000, 1'b0, 1'b1, 5'd9);

        // vl_cur differs at handshake (99) and in CALC (3); the CALC value must win.
        issue("keep", enc_vl(5'd3, 5'd0, 5'd0), 32'd0, 32'h010, 32'd99, 32'd3);
        done_chk("keep", 32'd3, 32'h0100_0000, 1'b0, 1'b0, 5'd0);

        issue("e64", enc_vli(11'h018, 5'd1, 5'd6), 32'd10, 32'd0, 32'd0, 32'd0);
        done_chk("e64", 32'd0, 32'd0, 1'b1, 1'b1, 5'd6);

        issue("m100", enc_vli(11'h004, 5'd1, 5'd6), 32'd10, 32'd0, 32'd0, 32'd0);
        done_chk("m100", 32'd0, 32'd0, 1'b1, 1'b1, 5'd6);

        issue("vl_rs2hi", enc_vl(5'd3, 5'd1, 5'd4), 32'd5, 32'h0000_0810, 32'd0, 32'd0);
        done_chk("vl_rs2hi", 32'd0, 32'd0, 1'b1, 1'b1, 5'd4);

        // Non-config: goes straight to DONE in the cycle after the handshake.
        instr = 32'h0000_0013; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ill.illegal", {31'd0, illegal}, 32'd1);
        chk("ill.wr", {31'd0, vconfig_wr_en}, 32'd0);
        chk("ill.rd_we", {31'd0, rd_we}, 32'd0);
        chk("ill.ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("ill.post", {31'd0, illegal}, 32'd0);
        chk("ill.post_ready", {31'd0, in_ready}, 32'd1);

        // Reset during CALC aborts the write.
        instr = enc_vli(11'h010, 5'd1, 5'd5); rs1_data = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort.ready_now", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("abort.wr", {31'd0, vconfig_wr_en}, 32'd0);
        chk("abort.ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort.wr2", {31'd0, vconfig_wr_en}, 32'd0);

        // Back-to-back valid: ready low for two cycles, then a second handshake.
        instr = enc_vli(11'h010, 5'd1, 5'd5); rs1_data = 32'd20; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("b2b.r0", {31'd0, in_ready}, 32'd0);
        chk("b2b.w0", {31'd0, vconfig_wr_en}, 32'd0);
        @(negedge clk);
        chk("b2b.r1", {31'd0, in_ready}, 32'd0);
        chk("b2b.w1", {31'd0, vconfig_wr_en}, 32'd1);
        @(negedge clk);
        chk("b2b.r2", {31'd0, in_ready}, 32'd1);
        chk("b2b.w2", {31'd0, vconfig_wr_en}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b.r3", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("b2b.w4", {31'd0, vconfig_wr_en}, 32'd1);
        @(negedge clk);

        issue("split", enc_vli(11'h010, 5'd1, 5'd5), 32'd12, 32'd0, 32'd0, 32'd0);
`ifdef VCFG_AVL_SPLIT_EN
        done_chk("split", 32'd6, 32'h0100_0000, 1'b0, 1'b1, 5'd5);
`else
        done_chk("split", 32'd8, 32'h0100_0000, 1'b0, 1'b1, 5'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
